// File: rtl/cplx_accum_seq.sv
// Block accumulator sequencer that feeds an external complex adder and collects its results.
// Latency: 1 cycle for the first sample, 1+ADD_LAT cycles per later sample, +1 cycle to emit the sum.
// Backpressure: in_ready is high only in FIRST/GET; samples offered at any other time are left unconsumed.
module cplx_accum_seq #(
  parameter int WIDTH   = 48,
  parameter int ADD_LAT = 3,
  parameter int CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             sub_mode,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_mode,
  input  logic [WIDTH-1:0] add_result,
  output logic [WIDTH-1:0] sum_out,
  output logic             sum_valid,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRST,
    S_GET,
    S_WAIT,
    S_DONE
  } state_t;

  // Counter reload value: the result is taken on the ADD_LAT-th edge after issue.
  localparam logic [3:0] WAIT_INIT = 4'(ADD_LAT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] len_q;
  logic             mode_q;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;
  logic [3:0]       wait_cnt;
  logic [WIDTH-1:0] acc;
  logic             xfer;
  logic             wait_done;

  assign in_ready  = (state == S_FIRST) || (state == S_GET);
  assign busy      = (state != S_IDLE);
  assign xfer      = in_valid && in_ready;
  assign wait_done = (wait_cnt == 4'd0);
  // count stays below len while waiting, so this increment cannot wrap.
  assign count_inc = count + 1'b1;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (len == '0) ? S_DONE : S_FIRST;
        end
      end
      S_FIRST: begin
        if (xfer) begin
          state_nxt = (len_q == CNT_W'(1)) ? S_DONE : S_GET;
        end
      end
      S_GET: begin
        if (xfer) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_done) begin
          state_nxt = (count_inc == len_q) ? S_DONE : S_GET;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Block parameters, running sum, adder operands and the result register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      len_q     <= '0;
      mode_q    <= 1'b0;
      count     <= '0;
      wait_cnt  <= 4'd0;
      acc       <= '0;
      add_a     <= '0;
      add_b     <= '0;
      add_mode  <= 1'b0;
      sum_out   <= '0;
      sum_valid <= 1'b0;
    end else begin
      sum_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q  <= len;
            mode_q <= sub_mode;
            count  <= '0;
            // An empty block reports the all-zero word.
            if (len == '0) begin
              acc <= '0;
            end
          end
        end
        S_FIRST: begin
          // First sample seeds the sum directly; the adder is not involved.
          if (xfer) begin
            acc   <= in_data;
            count <= CNT_W'(1);
          end
        end
        S_GET: begin
          // Operands hold until the next issue so the adder sees stable inputs.
          if (xfer) begin
            add_a    <= acc;
            add_b    <= in_data;
            add_mode <= mode_q;
            wait_cnt <= WAIT_INIT;
          end
        end
        S_WAIT: begin
          if (wait_done) begin
            acc   <= add_result;
            count <= count_inc;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_DONE: begin
          sum_out   <= acc;
          sum_valid <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cplx_accum_seq.sv
// Randomized scoreboard bench for cplx_accum_seq with an integer stand-in for the complex adder.
// Expected sums are computed from the sample lists and queued at start; a monitor checks each sum_valid.
// Sample feeding applies random in_valid gaps, stray starts while busy and in_valid while not ready.
module tb_cplx_accum_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        sub_mode = 1'b0;
  logic [47:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [47:0] add_a;
  logic [47:0] add_b;
  logic        add_mode;
  logic [47:0] add_result;
  logic [47:0] sum_out;
  logic        sum_valid;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int nvalid = 0;
  int vcyc = 0;
  logic prev_sv = 1'b0;

  logic [47:0] exp_q[$];
  logic [47:0] blk[$];
  logic [47:0] p0, p1;

  cplx_accum_seq dut (
    .clock     (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .sub_mode  (sub_mode),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_mode  (add_mode),
    .add_result(add_result),
    .sum_out   (sum_out),
    .sum_valid (sum_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [47:0] cadd(input logic [47:0] a, input logic [47:0] b, input logic m);
    logic [23:0] re, im;
    re = m ? (a[47:24] - b[47:24]) : (a[47:24] + b[47:24]);
    im = m ? (a[23:0] - b[23:0]) : (a[23:0] + b[23:0]);
    return {re, im};
  endfunction

  function automatic logic [47:0] rnd48();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[47:0];
  endfunction

  // Reference: fold the block's sample list, first sample seeds the sum.
  function automatic logic [47:0] block_sum(input int n, input logic m);
    logic [47:0] s;
    s = '0;
    for (int i = 0; i < n; i++) s = (i == 0) ? blk[i] : cadd(s, blk[i], m);
    return s;
  endfunction

  // Stand-in adder: result valid on the third edge after operands are registered.
  always @(posedge clk) begin
    p0 <= cadd(add_a, add_b, add_mode);
    p1 <= p0;
  end
  assign add_result = p1;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (sum_valid) begin
      nvalid++;
      vcyc = cyc;
      check("busy_low_with_sum_valid", 48'(busy), 48'(0));
      check("sum_valid_one_cycle", 48'(prev_sv), 48'(0));
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_sum_valid: got %h expected none", sum_out);
      end else begin
        check("sum_out", sum_out, exp_q.pop_front());
      end
    end
    prev_sv = sum_valid;
  end

  // Run one block from blk; returns start-to-sum_valid cycles and whether in_ready was seen.
  task automatic run_block(input int n, input logic sb, input int gap_pct, input bit poke,
                           input bit wild, output int lat, output bit saw_rdy);
    int idx, guard, v0, tstart;
    bit chk;
    logic [47:0] run, a_exp, b_exp;
    idx = 0; guard = 0; chk = 0; run = '0; saw_rdy = 0;
    a_exp = '0; b_exp = '0;
    @(negedge clk);
    start = 1'b1; len = 8'(n); sub_mode = sb;
    exp_q.push_back(block_sum(n, sb));
    tstart = cyc; v0 = nvalid;
    @(negedge clk);
    start = 1'b0;
    len = 8'($urandom_range(255));
    sub_mode = 1'($urandom_range(1));
    while (idx < n && guard < 5000) begin
      if (in_ready) saw_rdy = 1;
      start = (poke && $urandom_range(3) == 0);
      if (in_ready) begin
        in_valid = ($urandom_range(99) >= gap_pct);
        in_data  = blk[idx];
      end else begin
        in_valid = wild ? 1'($urandom_range(1)) : 1'b0;
        in_data  = rnd48();
      end
      if (in_valid && in_ready) begin
        if (idx == 0) run = blk[0];
        else begin
          a_exp = run; b_exp = blk[idx]; chk = 1;
          run = cadd(run, blk[idx], sb);
        end
        idx++;
      end
      @(negedge clk);
      guard++;
      if (chk) begin
        check("add_a", add_a, a_exp);
        check("add_b", add_b, b_exp);
        check("add_mode", 48'(add_mode), 48'(sb));
        chk = 0;
      end
    end
    if (idx < n) begin
      errors++;
      $display("FAIL sample_feed_timeout: got %0d samples expected %0d", idx, n);
    end
    start = 1'b0;
    in_valid = wild;
    in_data = rnd48();
    guard = 0;
    while (nvalid == v0 && guard < 200) begin
      if (in_ready) saw_rdy = 1;
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    if (nvalid == v0) begin
      errors++;
      $display("FAIL sum_valid_timeout: got none expected one");
      lat = -1;
    end else begin
      lat = vcyc - tstart;
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int lat, idx, guard;
    bit saw;
    logic [47:0] a_prev, b_prev;

    #1 reset = 1'b1;
    #1;
    check("rst_in_ready", 48'(in_ready), 48'(0));
    check("rst_busy", 48'(busy), 48'(0));
    check("rst_sum_valid", 48'(sum_valid), 48'(0));
    check("rst_sum_out", sum_out, 48'(0));
    check("rst_add_a", add_a, 48'(0));
    check("rst_add_b", add_b, 48'(0));
    check("rst_add_mode", 48'(add_mode), 48'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Directed sum with in_valid held high.
    blk = '{48'h000001_000002, 48'h000010_000020, 48'h000100_000200, 48'h001000_002000};
    run_block(4, 1'b0, 0, 0, 0, lat, saw);
    check("len4_latency", 48'(lat), 48'(15));

    // Subtract mode.
    blk = '{48'h000100_000100, 48'h000010_000001, 48'h000001_000010};
    check("sub_model_sanity", block_sum(3, 1'b1), 48'h0000EF_0000EF);
    run_block(3, 1'b1, 0, 0, 0, lat, saw);
    check("len3_latency", 48'(lat), 48'(11));

    // Empty block.
    run_block(0, 1'b0, 0, 0, 1, lat, saw);
    check("len0_latency", 48'(lat), 48'(2));
    check("len0_no_in_ready", 48'(saw), 48'(0));

    // Single sample: adder operands must not move.
    a_prev = add_a; b_prev = add_b;
    blk = '{48'h00ABCD_001234};
    run_block(1, 1'b0, 0, 0, 0, lat, saw);
    check("len1_add_a_hold", add_a, a_prev);
    check("len1_add_b_hold", add_b, b_prev);

    // Gaps, stray starts while busy, in_valid while waiting.
    blk = '{48'h000001_000002, 48'h000010_000020, 48'h000100_000200, 48'h001000_002000};
    run_block(4, 1'b0, 40, 1, 1, lat, saw);

    // Reset during the adder wait of the second sample.
    @(negedge clk);
    start = 1'b1; len = 8'd4; sub_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    idx = 0; guard = 0;
    while (idx < 2 && guard < 50) begin
      in_valid = 1'b1;
      in_data = blk[idx];
      if (in_ready) idx++;
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    check("pre_reset_in_wait", {in_ready, busy}, 48'b01);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", 48'(busy), 48'(0));
    check("mid_rst_in_ready", 48'(in_ready), 48'(0));
    check("mid_rst_add_a", add_a, 48'(0));
    check("mid_rst_add_b", add_b, 48'(0));
    check("mid_rst_sum_out", sum_out, 48'(0));
    check("mid_rst_sum_valid", 48'(sum_valid), 48'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    blk = '{48'h000005_000005, 48'h000003_000003};
    run_block(2, 1'b0, 0, 0, 0, lat, saw);
    check("post_reset_latency", 48'(lat), 48'(7));

    // Random blocks.
    for (int b = 0; b < 10; b++) begin
      int n;
      n = $urandom_range(6);
      blk.delete();
      for (int i = 0; i < n; i++) blk.push_back(rnd48());
      run_block(n, 1'($urandom_range(1)), 30, 1, 1, lat, saw);
    end

    // Longest block: count must reach 255 without wrapping.
    blk.delete();
    for (int i = 0; i < 255; i++) blk.push_back(rnd48());
    run_block(255, 1'b1, 0, 0, 0, lat, saw);
    check("len255_latency", 48'(lat), 48'(2 + 254 * 4 + 1));

    check("scoreboard_drained", 48'(exp_q.size()), 48'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cplx_accum_seq.md
Name: cplx_accum_seq

Overview:
- Sequencer directly upstream of the complex FP adder/subtractor stage (48-bit complex: real in [47:24], imag in [23:0], each a 24-bit float).
- Accepts a block of LEN complex samples over a valid/ready stream.
- Feeds running-sum/new-sample operand pairs to the external adder and waits its fixed pipeline latency before each write-back.
- Emits the accumulated complex sum with a one-cycle valid pulse. Used for block-sum stages of the integration datapath.

Parameters:
WIDTH, 48, complex word width (two WIDTH/2 floats, real half high).
ADD_LAT, 3, adder latency in clock edges from operands registered to add_result valid; legal range 1..15.
CNT_W, 8, width of sample counter and len port.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  begin a block; sampled only in IDLE.
len  input  CNT_W  number of samples in block; latched on start.
sub_mode  input  1  0 = acc+x, 1 = acc-x for samples 2..len; latched on start.
in_data  input  WIDTH  complex sample.
in_valid  input  1  in_data valid.
in_ready  output  1  block accepts in_data this cycle.
add_a  output  WIDTH  adder operand 1 (running sum).
add_b  output  WIDTH  adder operand 2 (new sample).
add_mode  output  1  adder mode, equals latched sub_mode.
add_result  input  WIDTH  adder output.
sum_out  output  WIDTH  final accumulated sum, held until next DONE.
sum_valid  output  1  one-cycle pulse when sum_out updates.
busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (async, active-high): state=IDLE; in_ready, sum_valid, busy, add_mode = 0; add_a, add_b, sum_out, acc = 0; counters = 0.
- All outputs are registered except in_ready and busy, which decode the state.
- A transfer occurs on a rising edge where in_valid && in_ready.
- IDLE: in_ready=0.
  - start=1: latch len and sub_mode, count=0.
  - len==0: go to DONE with acc=0.
  - Otherwise go to FIRST.
- FIRST: in_ready=1.
  - On transfer: acc<=in_data (no adder use), count<=1.
  - Then go to DONE if len==1, else GET.
- GET: in_ready=1.
  - On transfer: add_a<=acc, add_b<=in_data, add_mode<=sub_mode, wait_cnt<=ADD_LAT-1, go to WAIT.
  - add_a/add_b stay stable until the next GET transfer.
- WAIT: in_ready=0.
  - wait_cnt decrements each edge.
  - On the edge where wait_cnt==0 (the ADD_LAT-th edge after the issuing edge): acc<=add_result, count<=count+1.
  - Then go to DONE if count+1==len, else GET.
- DONE: sum_out<=acc, sum_valid<=1 for exactly one cycle, then IDLE. busy is high in DONE and drops in the cycle sum_valid is high.
- Throughput: first sample takes 1 cycle; each later sample takes 1+ADD_LAT cycles. Total time from start to sum_valid for len=N≥2 is 2 + (N-1)(1+ADD_LAT) + 1 cycles.
- start while busy: ignored. Does not restart the block and does not re-latch len or sub_mode.
- in_valid outside FIRST/GET: ignored; the sample is not consumed.
- len is unsigned; len=2^CNT_W-1 must complete without counter wrap. count is compared for equality only and never exceeds len.
- Reset mid-block: immediate return to IDLE, partial sum discarded, no sum_valid. Any in-flight adder result is ignored.
- No arithmetic is performed locally. Zero sum for len=0 is the all-zero word.

Test Plan:
Use a bench adder model: add_result = per-half integer add (or subtract if mode) of add_a/add_b, delayed ADD_LAT=3 edges. This verifies control only.
1. len=4, sub_mode=0, samples {0x000001_000002, 0x000010_000020, 0x000100_000200, 0x001000_002000}, in_valid held high -> sum_out=0x001111_002222, sum_valid one cycle, 15 cycles from start to sum_valid.
2. len=3, sub_mode=1, samples {0x000100_000100, 0x000010_000001, 0x000001_000010} -> sum_out=0x0000EF_0000EF; add_mode=1 on each issue.
3. len=0 -> sum_valid 2 cycles after start, sum_out=0, in_ready never high. len=1 with sample 0x00ABCD_001234 -> sum_out equals that sample, add_a/add_b unchanged.
4. in_valid gaps in GET, start pulsed while busy, and in_valid asserted during WAIT -> no extra samples consumed, result same as scenario 1, len not re-latched.
5. Assert reset in WAIT of second sample -> all outputs 0 asynchronously; new block len=2 {0x000005_000005, 0x000003_000003} afterwards -> 0x000008_000008.
6. Connect the real adder stage with 1.0+2.0 in both halves (len=2) -> both halves of sum_out decode to 3.0.
